// File: rtl/rtc_frame_capture.sv
// rtc_frame_capture
//   Capture/double-buffer stage between the RTC read sequencer and the VGA
//   character renderer. A burst of NUM_FIELDS consecutive RTC bytes is sampled
//   into a shadow bank. The shadow bank is copied to the display bank in one step
//   on a frame tick, so the renderer never sees a half-updated time.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   inicioSecuencia in   start-of-burst level; its rising edge starts a burst
//   datoRTC         in   RTC field data, one field per cycle during a burst
//   frameTick       in   1-cycle pulse at start of vertical blanking
//   rdIdx           in   display-bank field index requested by the renderer
//   ovClr           in   clears the overrun flag
//   rdDato          out  registered display-bank field[rdIdx], 0 when out of range
//   captureBusy     out  burst in progress (lead-in or capture)
//   dataValid       out  display bank committed at least once since reset
//   overrun         out  sticky: a pending burst was discarded by a newer one
module rtc_frame_capture #(
    parameter int unsigned DW         = 8,
    parameter int unsigned NUM_FIELDS = 8,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned LEAD       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicioSecuencia,
    input  logic [DW-1:0]    datoRTC,
    input  logic             frameTick,
    input  logic [IDX_W-1:0] rdIdx,
    input  logic             ovClr,
    output logic [DW-1:0]    rdDato,
    output logic             captureBusy,
    output logic             dataValid,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_CAPTURE,
        S_PENDING
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FIELDS - 1);
    localparam logic [3:0]       LEAD_RELOAD = (LEAD >= 2) ? 4'(LEAD - 2) : 4'd0;

    state_t           state_q, state_d;
    logic             start_prev_q, start_prev_d;
    logic [3:0]       lead_cnt_q, lead_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    shadow_q  [NUM_FIELDS];
    logic [DW-1:0]    shadow_d  [NUM_FIELDS];
    logic [DW-1:0]    display_q [NUM_FIELDS];
    logic [DW-1:0]    display_d [NUM_FIELDS];
    logic [DW-1:0]    rd_dato_q, rd_dato_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;

    logic             start;
    logic             begin_burst;
    logic             commit;
    logic             ov_set;

    always_comb begin
        start_prev_d = inicioSecuencia;
        start        = inicioSecuencia & ~start_prev_q;

        state_d      = state_q;
        lead_cnt_d   = lead_cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        display_d    = display_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        begin_burst  = 1'b0;
        commit       = 1'b0;
        ov_set       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    begin_burst = 1'b1;
                end
            end
            S_LEAD: begin
                if (lead_cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    lead_cnt_d = lead_cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                shadow_d[idx_q] = datoRTC;
                if (idx_q == LAST_IDX) begin
                    state_d = S_PENDING;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_PENDING: begin
                if (frameTick) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
                // A start edge with a tick in the same cycle commits first, so
                // nothing is lost and no overrun is flagged.
                if (start) begin
                    begin_burst = 1'b1;
                    ov_set      = ~frameTick;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The edge cycle itself is the first lead-in cycle: LEAD=1 goes straight
        // to capture, LEAD=0 samples field 0 in the edge cycle.
        if (begin_burst) begin
            idx_d = '0;
            if (LEAD == 0) begin
                shadow_d[0] = datoRTC;
                if (NUM_FIELDS == 1) begin
                    state_d = S_PENDING;
                end else begin
                    state_d = S_CAPTURE;
                    idx_d   = IDX_W'(1);
                end
            end else if (LEAD == 1) begin
                state_d = S_CAPTURE;
            end else begin
                state_d    = S_LEAD;
                lead_cnt_d = LEAD_RELOAD;
            end
        end

        if (commit) begin
            display_d    = shadow_q;
            data_valid_d = 1'b1;
        end

        if (ovClr) begin
            overrun_d = 1'b0;
        end
        if (ov_set) begin
            overrun_d = 1'b1;
        end

        if ({1'b0, rdIdx} < (IDX_W + 1)'(NUM_FIELDS)) begin
            rd_dato_d = display_q[rdIdx];
        end else begin
            rd_dato_d = '0;
        end

        captureBusy = (state_q == S_LEAD) || (state_q == S_CAPTURE) || begin_burst;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            lead_cnt_q   <= '0;
            idx_q        <= '0;
            rd_dato_q    <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i]  <= '0;
                display_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            lead_cnt_q   <= lead_cnt_d;
            idx_q        <= idx_d;
            rd_dato_q    <= rd_dato_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
        end
    end

    assign rdDato    = rd_dato_q;
    assign dataValid = data_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rtc_frame_capture.sv
// tb_rtc_frame_capture
//   Directed bench for rtc_frame_capture: default instance (8 fields, LEAD=1)
//   plus a 6-field instance sharing the same stimulus for out-of-range reads.
module tb_rtc_frame_capture;

    typedef logic [7:0] fields_t [8];

    logic       clk = 1'b0;
    logic       reset;
    logic       ini;
    logic [7:0] dato;
    logic       tick;
    logic [2:0] rd_idx;
    logic       ov_clr;

    logic [7:0] rd_dato, rd_dato6;
    logic       busy, busy6;
    logic       valid, valid6;
    logic       ovr, ovr6;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    rtc_frame_capture #(.DW(8), .NUM_FIELDS(8), .IDX_W(3), .LEAD(1)) dut (
        .clk(clk), .reset(reset), .inicioSecuencia(ini), .datoRTC(dato),
        .frameTick(tick), .rdIdx(rd_idx), .ovClr(ov_clr), .rdDato(rd_dato),
        .captureBusy(busy), .dataValid(valid), .overrun(ovr)
    );

    rtc_frame_capture #(.DW(8), .NUM_FIELDS(6), .IDX_W(3), .LEAD(1)) dut6 (
        .clk(clk), .reset(reset), .inicioSecuencia(ini), .datoRTC(dato),
        .frameTick(tick), .rdIdx(rd_idx), .ovClr(ov_clr), .rdDato(rd_dato6),
        .captureBusy(busy6), .dataValid(valid6), .overrun(ovr6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Edge cycle (data ignored) then 8 field cycles; leaves ini high.
    task automatic burst(input fields_t f, input string tag, input bit clr_edge,
                         input bit tick_edge, input bit tick_last);
        ini = 1'b1; dato = 8'd0; ov_clr = clr_edge; tick = tick_edge;
        #1; chk({tag, " busy edge"}, busy, 1);
        cyc();
        ov_clr = 1'b0; tick = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dato = f[i];
            tick = (i == 7) && tick_last;
            #1; chk($sformatf("%s busy f%0d", tag, i), busy, 1);
            cyc();
        end
        tick = 1'b0; dato = 8'd0;
        #1; chk({tag, " busy after"}, busy, 0);
    endtask

    task automatic read_all(input fields_t f, input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            cyc();
            chk($sformatf("%s rd%0d", tag, i), rd_dato, f[i]);
        end
    endtask

    fields_t zero = '{0, 0, 0, 0, 0, 0, 0, 0};
    fields_t fa   = '{24, 4, 3, 23, 12, 17, 5, 4};
    fields_t fb   = '{45, 30, 10, 15, 6, 24, 3, 2};
    fields_t fc   = '{25, 59, 22, 1, 1, 24, 1, 7};
    fields_t fd   = '{26, 0, 23, 2, 2, 24, 2, 1};
    fields_t fe   = '{27, 1, 0, 3, 3, 24, 3, 6};
    fields_t fg   = '{10, 11, 12, 13, 14, 15, 16, 17};
    fields_t fh   = '{50, 51, 52, 53, 54, 55, 56, 57};

    initial begin
        reset = 1'b1; ini = 1'b0; dato = 8'd0; tick = 1'b0; rd_idx = 3'd0; ov_clr = 1'b0;
        cyc(); cyc();
        chk("rst rdDato", rd_dato, 0);
        chk("rst busy", busy, 0);
        chk("rst valid", valid, 0);
        chk("rst overrun", ovr, 0);
        reset = 1'b0;
        cyc();

        // 1: burst without frame tick leaves display empty
        burst(fa, "A", 1'b0, 1'b0, 1'b0);
        chk("A busy6 pending", busy6, 0);
        ini = 1'b0; cyc();
        read_all(zero, "A nocommit");
        chk("A valid before tick", valid, 0);

        // 2: frame tick commits; 6-field instance returns 0 beyond its range
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("A valid", valid, 1);
        read_all(fa, "A commit");
        rd_idx = 3'd5; cyc(); chk("A6 rd5", rd_dato6, 17);
        rd_idx = 3'd6; cyc(); chk("A6 rd6", rd_dato6, 0);
        rd_idx = 3'd7; cyc(); chk("A6 rd7", rd_dato6, 0);
        chk("A6 valid", valid6, 1);

        // 3: held level for 11 cycles gives one burst only
        burst(fb, "B", 1'b0, 1'b0, 1'b0);
        dato = 8'd2; cyc();
        #1; chk("B held busy", busy, 0);
        cyc();
        ini = 1'b0; cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        read_all(fb, "B commit");
        tick = 1'b1; cyc(); tick = 1'b0;
        rd_idx = 3'd0; cyc(); chk("B idle tick", rd_dato, 45);
        dato = 8'd0;

        // 4: new burst over a pending one flags overrun (set beats clear)
        burst(fc, "C", 1'b0, 1'b0, 1'b0);
        ini = 1'b0; cyc();
        chk("C overrun", ovr, 0);
        rd_idx = 3'd0; cyc(); chk("C pending rd0", rd_dato, 45);
        burst(fd, "D", 1'b1, 1'b0, 1'b0);
        chk("D overrun", ovr, 1);
        chk("D6 overrun", ovr6, 1);
        ini = 1'b0; cyc();
        ov_clr = 1'b1; cyc(); ov_clr = 1'b0;
        chk("D ovclr", ovr, 0);

        // 4/5: tick with start commits D without overrun; tick on last field
        // of E does not commit
        burst(fe, "E", 1'b0, 1'b1, 1'b1);
        ini = 1'b0; cyc();
        chk("E no overrun", ovr, 0);
        read_all(fd, "D commit");
        tick = 1'b1; cyc(); tick = 1'b0;
        read_all(fe, "E commit");

        // 6a: reset mid-capture
        ini = 1'b1; dato = 8'd0; cyc();
        dato = 8'd91; cyc();
        dato = 8'd92; cyc();
        dato = 8'd93;
        #1; chk("F busy mid", busy, 1);
        chk("F rdDato pre", rd_dato, 6);
        reset = 1'b1; ini = 1'b0;
        #1;
        chk("F rst rdDato", rd_dato, 0);
        chk("F rst busy", busy, 0);
        chk("F rst valid", valid, 0);
        chk("F rst overrun", ovr, 0);
        cyc(); reset = 1'b0; dato = 8'd0; cyc();
        rd_idx = 3'd3; cyc(); chk("F display cleared", rd_dato, 0);

        // 6b: reset after a commit with overrun set
        burst(fg, "G", 1'b0, 1'b0, 1'b0);
        ini = 1'b0; cyc();
        burst(fh, "H", 1'b0, 1'b0, 1'b0);
        ini = 1'b0; cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        rd_idx = 3'd7; cyc();
        chk("H rd7", rd_dato, 57);
        chk("H overrun", ovr, 1);
        chk("H valid", valid, 1);
        reset = 1'b1;
        #1;
        chk("H rst rdDato", rd_dato, 0);
        chk("H rst valid", valid, 0);
        chk("H rst overrun", ovr, 0);
        chk("H rst busy", busy, 0);
        cyc(); reset = 1'b0; cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("H idle after rst", valid, 0);
        rd_idx = 3'd0; cyc(); chk("H rd0 after rst", rd_dato, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
